// File: rtl/pong_game_controller_if.sv
// Control/status bundle between the Pong game-flow sequencer and its neighbours
// (push-button/ball logic on the input side, display manager and ball datapath on the output side).
interface pong_game_controller_if;
  logic       start;
  logic       point0;
  logic       point1;
  logic       running;
  logic [3:0] score0;
  logic [3:0] score1;
  logic       winner;
  logic       game_over;
  logic       ball_hold;
  logic       launch;
  logic       serve_dir;

  modport master (
    output start, point0, point1,
    input  running, score0, score1, winner, game_over, ball_hold, launch, serve_dir
  );

  modport slave (
    input  start, point0, point1,
    output running, score0, score1, winner, game_over, ball_hold, launch, serve_dir
  );
endinterface

// File: rtl/pong_game_controller.sv
// Pong match sequencer: scores points, holds and serves the ball, detects the winner.
// Every output is a register; next values are derived from the next FSM state.
module pong_game_controller #(
  parameter int unsigned WIN_SCORE    = 9,
  parameter int unsigned SERVE_CYCLES = 50000000,
  parameter int unsigned PAUSE_CYCLES = 25000000
) (
  input logic                    clock,
  input logic                    reset,
  pong_game_controller_if.slave  bus
);

  localparam int unsigned MaxCycles = (SERVE_CYCLES > PAUSE_CYCLES) ? SERVE_CYCLES : PAUSE_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);
  localparam logic [CntW-1:0] ServeLoad = CntW'(SERVE_CYCLES - 1);
  localparam logic [CntW-1:0] PauseLoad = CntW'(PAUSE_CYCLES - 1);
  localparam logic [3:0]      WinScore  = 4'(WIN_SCORE);

  typedef enum logic [2:0] {StIdle, StServe, StPlay, StPause, StGameOver} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      score0_q, score0_d, score1_q, score1_d;
  logic            winner_q, winner_d;
  logic            serve_dir_q, serve_dir_d;
  logic            launch_q, launch_d;
  logic            running_q, running_d;
  logic            ball_hold_q, ball_hold_d;
  logic            game_over_q, game_over_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    score0_d    = score0_q;
    score1_d    = score1_q;
    winner_d    = winner_q;
    serve_dir_d = serve_dir_q;
    launch_d    = 1'b0;

    case (state_q)
      StIdle, StGameOver: begin
        if (bus.start) begin
          score0_d    = 4'd0;
          score1_d    = 4'd0;
          winner_d    = 1'b0;
          serve_dir_d = 1'b0;
          cnt_d       = ServeLoad;
          state_d     = StServe;
        end
      end
      StServe: begin
        if (cnt_q == '0) begin
          launch_d = 1'b1;
          state_d  = StPlay;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StPlay: begin
        // point0 has priority; a simultaneous point1 is dropped.
        if (bus.point0) begin
          score0_d    = score0_q + 4'd1;
          serve_dir_d = 1'b1;
          if (score0_d == WinScore) begin
            winner_d = 1'b0;
            state_d  = StGameOver;
          end else begin
            cnt_d   = PauseLoad;
            state_d = StPause;
          end
        end else if (bus.point1) begin
          score1_d    = score1_q + 4'd1;
          serve_dir_d = 1'b0;
          if (score1_d == WinScore) begin
            winner_d = 1'b1;
            state_d  = StGameOver;
          end else begin
            cnt_d   = PauseLoad;
            state_d = StPause;
          end
        end
      end
      StPause: begin
        if (cnt_q == '0) begin
          cnt_d   = ServeLoad;
          state_d = StServe;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    running_d   = (state_d == StServe) || (state_d == StPlay) || (state_d == StPause);
    ball_hold_d = (state_d != StPlay);
    game_over_d = (state_d == StGameOver);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      score0_q    <= 4'd0;
      score1_q    <= 4'd0;
      winner_q    <= 1'b0;
      serve_dir_q <= 1'b0;
      launch_q    <= 1'b0;
      running_q   <= 1'b0;
      ball_hold_q <= 1'b1;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      score0_q    <= score0_d;
      score1_q    <= score1_d;
      winner_q    <= winner_d;
      serve_dir_q <= serve_dir_d;
      launch_q    <= launch_d;
      running_q   <= running_d;
      ball_hold_q <= ball_hold_d;
      game_over_q <= game_over_d;
    end
  end

  assign bus.running   = running_q;
  assign bus.score0    = score0_q;
  assign bus.score1    = score1_q;
  assign bus.winner    = winner_q;
  assign bus.game_over = game_over_q;
  assign bus.ball_hold = ball_hold_q;
  assign bus.launch    = launch_q;
  assign bus.serve_dir = serve_dir_q;

endmodule

// File: tb/tb_pong_game_controller.sv
// Directed, table-driven bench for pong_game_controller with WIN_SCORE=3, SERVE=4, PAUSE=3.
// Expected vector layout: {running, score0, score1, game_over, winner, ball_hold, launch, serve_dir}.
module tb_pong_game_controller;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  pong_game_controller_if bus ();

  pong_game_controller #(
    .WIN_SCORE   (3),
    .SERVE_CYCLES(4),
    .PAUSE_CYCLES(3)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic        start;
    logic        point0;
    logic        point1;
    logic [13:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  localparam logic [13:0] RstOuts = {1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  task automatic add(input logic st, input logic p0, input logic p1, input logic run,
                     input logic [3:0] s0, input logic [3:0] s1, input logic go,
                     input logic win, input logic hold, input logic lau, input logic dir);
    vec_t v;
    v.start  = st;
    v.point0 = p0;
    v.point1 = p1;
    v.exp    = {run, s0, s1, go, win, hold, lau, dir};
    vecs.push_back(v);
  endtask

  // n idle cycles with the ball held (PAUSE/SERVE), then the launch cycle.
  task automatic add_wait(input int n, input logic [3:0] s0, input logic [3:0] s1,
                          input logic dir);
    for (int i = 0; i < n; i++) add(1'b0, 1'b0, 1'b0, 1'b1, s0, s1, 1'b0, 1'b0, 1'b1, 1'b0, dir);
    add(1'b0, 1'b0, 1'b0, 1'b1, s0, s1, 1'b0, 1'b0, 1'b0, 1'b1, dir);
  endtask

  function automatic logic [13:0] outs();
    return {bus.running, bus.score0, bus.score1, bus.game_over, bus.winner, bus.ball_hold,
            bus.launch, bus.serve_dir};
  endfunction

  task automatic check(input string name, input logic [13:0] exp);
    logic [13:0] got;
    got = outs();
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b required %b (run,s0,s1,go,win,hold,launch,dir)", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.point0 = 1'b0;
    bus.point1 = 1'b0;
    reset      = 1'b1;

    repeat (5) tick();
    check("reset_state", RstOuts);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle", RstOuts);
    end

    // start, serve, first launch
    add(1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0);
    add_wait(3, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    // point0, ignored point0 and start in PAUSE, next launch 7 cycles after the point
    add(0, 1, 0, 1, 1, 0, 0, 0, 1, 0, 1);
    add(0, 1, 0, 1, 1, 0, 0, 0, 1, 0, 1);
    add(1, 0, 0, 1, 1, 0, 0, 0, 1, 0, 1);
    add_wait(4, 1, 0, 1);
    // start in PLAY ignored, then simultaneous points
    add(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1);
    add(0, 1, 1, 1, 2, 0, 0, 0, 1, 0, 1);
    add_wait(6, 2, 0, 1);
    // player 1 wins 3 points
    add(0, 0, 1, 1, 2, 1, 0, 0, 1, 0, 0);
    add_wait(6, 2, 1, 0);
    add(0, 0, 1, 1, 2, 2, 0, 0, 1, 0, 0);
    add_wait(6, 2, 2, 0);
    add(0, 0, 1, 0, 2, 3, 1, 1, 1, 0, 0);
    add(0, 1, 0, 0, 2, 3, 1, 1, 1, 0, 0);
    add(0, 0, 1, 0, 2, 3, 1, 1, 1, 0, 0);
    // restart from GAME_OVER
    add(1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0);
    add_wait(3, 0, 0, 0);
    // build 2/1 and stop in PAUSE
    add(0, 1, 0, 1, 1, 0, 0, 0, 1, 0, 1);
    add_wait(6, 1, 0, 1);
    add(0, 1, 0, 1, 2, 0, 0, 0, 1, 0, 1);
    add_wait(6, 2, 0, 1);
    add(0, 0, 1, 1, 2, 1, 0, 0, 1, 0, 0);

    foreach (vecs[i]) begin
      bus.start  = vecs[i].start;
      bus.point0 = vecs[i].point0;
      bus.point1 = vecs[i].point1;
      tick();
      check($sformatf("vec%0d", i), vecs[i].exp);
    end
    bus.start  = 1'b0;
    bus.point0 = 1'b0;
    bus.point1 = 1'b0;

    // mid-PAUSE reset with 2/1, must not launch afterwards
    add_wait(0, 2, 1, 0);
    vecs.delete();
    reset = 1'b1;
    tick();
    check("mid_pause_reset", RstOuts);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("post_reset_idle", RstOuts);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
